calc_operand_entry: RTL and testbench
=====================================

// Module: calc_operand_entry
// PURPOSE
//  Keypad entry stage upstream of the calculator arithmetic block. Turns debounced key
//  events into two 0..99 operands and an operator code, then issues a one-cycle go
//  pulse that the arithmetic stage latches on. Sits between the keypad scanner/debouncer
//  and the arithmetic unit; active only in calculator mode.
// PARAMETERS
//  MAX_DIGITS  2   decimal digits accepted per operand (2 -> max 99, fits 7 bits)
//  OPW         7   operand output width in bits
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  rst_n       in   1    asynchronous active-low reset
//  modo        in   1    1 = calculator mode; 0 = all keys ignored, state and outputs held
//  key_valid   in   1    one-cycle strobe, key_code valid; back-to-back strobes allowed
//  key_code    in   4    0-9 digit, 10 A add, 11 B sub, 12 C mul, 13 D clear, 14 E equals, 15 F
//  in1         out  OPW  operand 1, binary
//  in2         out  OPW  operand 2, binary
//  op_code     out  4    operator for arithmetic stage (10/11/12, or 13 on clear)
//  pressed     out  1    one-cycle go pulse to arithmetic stage
//  entry_st    out  2    current FSM state for display mux (0 OP1, 1 OP2, 2 RESULT)
// BEHAVIOUR
//  Reset: in1=0, in2=0, op_code=0, pressed=0, entry_st=OP1, both digit counters=0.
//  All actions occur on the clk edge sampling key_valid=1 && modo=1. Outputs registered;
//  pressed rises the cycle after the key edge.
//  in1, in2 and op_code are stable from that cycle until the next accepted key.
//  Digit entry: value <= value*10 + digit, only while digit count < MAX_DIGITS; further
//   digits are ignored, with no value change. Arithmetic stays in OPW bits; no overflow
//   is possible (99 max).
//  OP1: digit -> accumulate in1. A/B/C -> op_code<=key, go OP2 (in1 may be 0 digits = 0).
//       E ignored. F ignored unless backspace is enabled.
//  OP2: digit -> accumulate in2. A/B/C -> replace op_code, stay OP2 (no chaining).
//       E with in2 count>=1 -> pressed=1 for one cycle, go RESULT. E with count 0 ignored.
//  RESULT: digit -> in1<=digit, in2<=0, counts=(1,0), go OP1. A/B/C/E/F ignored.
//  D in any state: in1=in2=0, counts=0, op_code<=13, pressed=1 for one cycle, go OP1.
//   The pulse lets the arithmetic stage clear its sign flag.
//  modo=0: key_valid ignored. modo toggling does not clear state. A pending pressed
//   pulse still completes.
//  rst_n low mid-entry: immediate return to reset values. A pressed pulse in flight is
//   aborted.
//  pressed is never high two consecutive cycles unless two qualifying keys arrive
//   back-to-back.
// CONFIGURATION
//  CALC_ENTRY_BACKSPACE_EN defined: key F in OP1/OP2 removes last digit of the active
//   operand (value <= value/10, count-1; no-op at count 0). In OP2 with count 0 it
//   returns to OP1, keeping in1, and leaves op_code unchanged.
//  Undefined: key F ignored in all states; no divider logic is built.
// STRUCTURE
//  Shared package calc_pkg: KEY_A..KEY_F localparams (10..15), digit range check,
//   entry-state enum {ST_OP1, ST_OP2, ST_RESULT}. The arithmetic stage uses the same
//   package.
//  One sub-module: calc_digit_accum (value, count, load/append/backspace/clear),
//   instantiated twice, once per operand. The FSM and pressed generation stay in the top.
// TESTING
//  Keys 4,2,A,1,7,E -> in1=42, in2=17, op_code=10, single pressed pulse, entry_st=RESULT.
//  Keys 9,9,9,C,5,E -> in1=99 (third 9 dropped), in2=5, op_code=12, one pulse.
//  Keys 3,B,A,6,E -> op_code=10 (replaced); E before 6 produces no pulse.
//  Mid-OP2 press D -> in1=in2=0, op_code=13, one pulse, entry_st=OP1; then modo=0 plus
//   digit 7 -> no change.
//  After RESULT press 8 -> in1=8, in2=0, entry_st=OP1, no pulse.
//  Assert rst_n low during OP2 -> all outputs zero asynchronously.
//  With CALC_ENTRY_BACKSPACE_EN: keys 5,6,F,A -> in1=5.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared keypad/calculator definitions: key codes, entry-state encoding and
// digit-accumulator commands, used by the entry stage and the arithmetic stage.
package calc_pkg;

    localparam logic [3:0] KEY_A = 4'd10;  // add
    localparam logic [3:0] KEY_B = 4'd11;  // subtract
    localparam logic [3:0] KEY_C = 4'd12;  // multiply
    localparam logic [3:0] KEY_D = 4'd13;  // clear
    localparam logic [3:0] KEY_E = 4'd14;  // equals
    localparam logic [3:0] KEY_F = 4'd15;  // backspace when enabled

    typedef enum logic [1:0] {
        ST_OP1    = 2'd0,
        ST_OP2    = 2'd1,
        ST_RESULT = 2'd2
    } entry_state_e;

    typedef enum logic [2:0] {
        ACC_HOLD,
        ACC_CLEAR,
        ACC_LOAD,
        ACC_APPEND,
        ACC_BACK
    } acc_cmd_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] key);
        return (key == KEY_A) || (key == KEY_B) || (key == KEY_C);
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: holds a binary value and its digit count.
// Backspace (divide by 10) is only built when CALC_ENTRY_BACKSPACE_EN is defined.
module calc_digit_accum
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int OPW        = 7,
    localparam int CNTW      = $clog2(MAX_DIGITS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  acc_cmd_e       cmd,
    input  logic [3:0]     digit,
    output logic [OPW-1:0] value,
    output logic           empty
);

    logic [OPW-1:0]  value_q, value_d;
    logic [CNTW-1:0] count_q, count_d;

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        case (cmd)
            ACC_CLEAR: begin
                value_d = '0;
                count_d = '0;
            end
            ACC_LOAD: begin
                value_d = OPW'(digit);
                count_d = CNTW'(1);
            end
            ACC_APPEND: begin
                // Digits beyond MAX_DIGITS are dropped without touching the value.
                if (count_q < CNTW'(MAX_DIGITS)) begin
                    value_d = value_q * OPW'(10) + OPW'(digit);
                    count_d = count_q + CNTW'(1);
                end
            end
`ifdef CALC_ENTRY_BACKSPACE_EN
            ACC_BACK: begin
                if (count_q != '0) begin
                    value_d = value_q / OPW'(10);
                    count_d = count_q - CNTW'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad entry FSM: builds two operands and an operator, pulses 'pressed' on E or D.
// Optional backspace on key F is enabled by defining CALC_ENTRY_BACKSPACE_EN.
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int OPW        = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           modo,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    output logic [OPW-1:0] in1,
    output logic [OPW-1:0] in2,
    output logic [3:0]     op_code,
    output logic           pressed,
    output logic [1:0]     entry_st
);

    // key_valid is a one-cycle strobe with no back-pressure: a key is taken on
    // every rising edge where key_valid && modo, including consecutive cycles.
    entry_state_e state_q, state_d;
    logic [3:0]   op_code_q, op_code_d;
    logic         pressed_q, pressed_d;
    acc_cmd_e     cmd1, cmd2;
    logic         empty1, empty2;
    logic         accept;

    assign accept = key_valid && modo;

    always_comb begin
        state_d   = state_q;
        op_code_d = op_code_q;
        pressed_d = 1'b0;
        cmd1      = ACC_HOLD;
        cmd2      = ACC_HOLD;
        if (accept) begin
            if (key_code == KEY_D) begin
                // An empty accumulator already holds zero, so it is left alone.
                cmd1      = empty1 ? ACC_HOLD : ACC_CLEAR;
                cmd2      = empty2 ? ACC_HOLD : ACC_CLEAR;
                op_code_d = KEY_D;
                pressed_d = 1'b1;
                state_d   = ST_OP1;
            end else begin
                case (state_q)
                    ST_OP1: begin
                        if (is_digit(key_code)) begin
                            cmd1 = ACC_APPEND;
                        end else if (is_operator(key_code)) begin
                            op_code_d = key_code;
                            state_d   = ST_OP2;
                        end
`ifdef CALC_ENTRY_BACKSPACE_EN
                        else if (key_code == KEY_F) begin
                            cmd1 = ACC_BACK;
                        end
`endif
                    end
                    ST_OP2: begin
                        if (is_digit(key_code)) begin
                            cmd2 = ACC_APPEND;
                        end else if (is_operator(key_code)) begin
                            op_code_d = key_code;
                        end else if (key_code == KEY_E && !empty2) begin
                            pressed_d = 1'b1;
                            state_d   = ST_RESULT;
                        end
`ifdef CALC_ENTRY_BACKSPACE_EN
                        else if (key_code == KEY_F) begin
                            if (empty2) state_d = ST_OP1;
                            else        cmd2    = ACC_BACK;
                        end
`endif
                    end
                    ST_RESULT: begin
                        // A digit after a result starts a fresh calculation.
                        if (is_digit(key_code)) begin
                            cmd1    = ACC_LOAD;
                            cmd2    = ACC_CLEAR;
                            state_d = ST_OP1;
                        end
                    end
                    default: state_d = ST_OP1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OP1;
            op_code_q <= 4'd0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_code_q <= op_code_d;
            pressed_q <= pressed_d;
        end
    end

    calc_digit_accum #(.MAX_DIGITS(MAX_DIGITS), .OPW(OPW)) u_acc1 (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd1),
        .digit (key_code),
        .value (in1),
        .empty (empty1)
    );

    calc_digit_accum #(.MAX_DIGITS(MAX_DIGITS), .OPW(OPW)) u_acc2 (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd2),
        .digit (key_code),
        .value (in2),
        .empty (empty2)
    );

    assign op_code  = op_code_q;
    assign pressed  = pressed_q;
    assign entry_st = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry: every key pushes its hand-computed
// expected outputs; a monitor compares them on the falling edge after the key.
module tb_calc_operand_entry;
    localparam int W = 21;  // {in1[7], in2[7], op_code[4], pressed[1], entry_st[2]}
`ifdef CALC_ENTRY_BACKSPACE_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       modo = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [6:0] in1, in2;
    logic [3:0] op_code;
    logic       pressed;
    logic [1:0] entry_st;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic seen = 1'b0;

    calc_operand_entry dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .modo      (modo),
        .key_valid (key_valid),
        .key_code  (key_code),
        .in1       (in1),
        .in2       (in2),
        .op_code   (op_code),
        .pressed   (pressed),
        .entry_st  (entry_st)
    );

    always #5 clk = ~clk;

    // Remember whether a key strobe was sampled at this rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen = 1'b0;
        else        seen = key_valid;
    end

    // Monitor: compare the response to each strobed key; otherwise no stray pulse.
    always @(negedge clk) begin
        logic [W-1:0] act, exp_v;
        if (rst_n) begin
            act = {in1, in2, op_code, pressed, entry_st};
            if (seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL key_response: no expected entry, got in1=%0d in2=%0d op=%0d pressed=%0d st=%0d",
                             in1, in2, op_code, pressed, entry_st);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act !== exp_v) begin
                        errors++;
                        $display("FAIL key_response @%0t: got in1=%0d in2=%0d op=%0d pressed=%0d st=%0d, want in1=%0d in2=%0d op=%0d pressed=%0d st=%0d",
                                 $time, in1, in2, op_code, pressed, entry_st,
                                 exp_v[20:14], exp_v[13:7], exp_v[6:3], exp_v[2], exp_v[1:0]);
                    end
                end
            end else begin
                checks++;
                if (pressed !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_pulse @%0t: got pressed=%0d, want 0", $time, pressed);
                end
            end
        end
    end

    task automatic send_key(input logic [3:0] k, input logic m,
                            input int e1, input int e2, input int eop,
                            input int ep, input int est, input bit hold);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        modo      = m;
        exp_q.push_back({7'(e1), 7'(e2), 4'(eop), 1'(ep), 2'(est)});
        if (!hold) begin
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({in1, in2, op_code, pressed, entry_st} !== '0) begin
            errors++;
            $display("FAIL %s: got in1=%0d in2=%0d op=%0d pressed=%0d st=%0d, want all 0",
                     name, in1, in2, op_code, pressed, entry_st);
        end
    endtask

    initial begin
        #12;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // 4 2 A 1 7 E
        send_key(4'd4,  1, 4,  0,  0, 0, 0, 0);
        send_key(4'd2,  1, 42, 0,  0, 0, 0, 0);
        send_key(4'd10, 1, 42, 0,  10, 0, 1, 0);
        send_key(4'd1,  1, 42, 1,  10, 0, 1, 0);
        send_key(4'd7,  1, 42, 17, 10, 0, 1, 0);
        send_key(4'd14, 1, 42, 17, 10, 1, 2, 0);
        // from RESULT: 9 9 9 C 5 E (third 9 dropped)
        send_key(4'd9,  1, 9,  0, 10, 0, 0, 0);
        send_key(4'd9,  1, 99, 0, 10, 0, 0, 0);
        send_key(4'd9,  1, 99, 0, 10, 0, 0, 0);
        send_key(4'd12, 1, 99, 0, 12, 0, 1, 0);
        send_key(4'd5,  1, 99, 5, 12, 0, 1, 0);
        send_key(4'd14, 1, 99, 5, 12, 1, 2, 0);
        // RESULT then 8
        send_key(4'd8,  1, 8, 0, 12, 0, 0, 0);
        // D 3 B E A 6 E
        send_key(4'd13, 1, 0, 0, 13, 1, 0, 0);
        send_key(4'd3,  1, 3, 0, 13, 0, 0, 0);
        send_key(4'd11, 1, 3, 0, 11, 0, 1, 0);
        send_key(4'd14, 1, 3, 0, 11, 0, 1, 0);
        send_key(4'd10, 1, 3, 0, 10, 0, 1, 0);
        send_key(4'd6,  1, 3, 6, 10, 0, 1, 0);
        send_key(4'd14, 1, 3, 6, 10, 1, 2, 0);
        // RESULT ignores A, E, F
        send_key(4'd10, 1, 3, 6, 10, 0, 2, 0);
        send_key(4'd14, 1, 3, 6, 10, 0, 2, 0);
        send_key(4'd15, 1, 3, 6, 10, 0, 2, 0);
        // 1 A 2, D mid-OP2, then modo=0 keys ignored
        send_key(4'd1,  1, 1, 0, 10, 0, 0, 0);
        send_key(4'd10, 1, 1, 0, 10, 0, 1, 0);
        send_key(4'd2,  1, 1, 2, 10, 0, 1, 0);
        send_key(4'd13, 1, 0, 0, 13, 1, 0, 0);
        send_key(4'd7,  0, 0, 0, 13, 0, 0, 0);
        send_key(4'd13, 0, 0, 0, 13, 0, 0, 0);
        // E in OP1 ignored
        send_key(4'd14, 1, 0, 0, 13, 0, 0, 0);
        // back-to-back: 3 A 0 0 9 E D (E with in2=0 but two digits still pulses)
        send_key(4'd3,  1, 3, 0, 13, 0, 0, 1);
        send_key(4'd10, 1, 3, 0, 10, 0, 1, 1);
        send_key(4'd0,  1, 3, 0, 10, 0, 1, 1);
        send_key(4'd0,  1, 3, 0, 10, 0, 1, 1);
        send_key(4'd9,  1, 3, 0, 10, 0, 1, 1);
        send_key(4'd14, 1, 3, 0, 10, 1, 2, 1);
        send_key(4'd13, 1, 0, 0, 13, 1, 0, 0);
        // 2 C 4 then asynchronous reset in OP2
        send_key(4'd2,  1, 2, 0, 13, 0, 0, 0);
        send_key(4'd12, 1, 2, 0, 12, 0, 1, 0);
        send_key(4'd4,  1, 2, 4, 12, 0, 1, 0);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // 5 6 F A F: backspace behaviour when enabled, otherwise F ignored
        send_key(4'd5,  1, 5,  0, 0, 0, 0, 0);
        send_key(4'd6,  1, 56, 0, 0, 0, 0, 0);
        send_key(4'd15, 1, BS ? 5 : 56, 0, 0, 0, 0, 0);
        send_key(4'd10, 1, BS ? 5 : 56, 0, 10, 0, 1, 0);
        send_key(4'd15, 1, BS ? 5 : 56, 0, 10, 0, BS ? 0 : 1, 0);
        send_key(4'd15, 1, BS ? 0 : 56, 0, 10, 0, BS ? 0 : 1, 0);
        send_key(4'd15, 1, BS ? 0 : 56, 0, 10, 0, BS ? 0 : 1, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
